// File: rtl/branch_predictor_if.sv
// Purpose : bundles the IF-side prediction and EX-side resolution signals of the branch predictor.
// Latency : n/a (signal container only).
// Backpr. : none; every field is sampled or produced every cycle.
//
// Ports (slave = predictor side):
//   if_pc                       -> PC of the instruction currently in IF
//   pred_taken, pred_target     <- IF prediction
//   ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
//   ex_pred_taken, ex_pred_target -> resolved outcome from EX plus the prediction that travelled with it
//   mispredict, redirect_pc     <- flush / fetch redirect
//   br_count, miss_count        <- saturating statistics
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               br_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Purpose : direct-mapped BHT/BTB (2-bit counters) predicting IF branches, checking EX outcomes, training on resolution.
// Latency : prediction and mispredict/redirect are combinational (0 cycles); table/counter updates land on the next edge.
// Backpr. : none; one EX resolution may be accepted every cycle, no stall is ever requested.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset (clears table and statistics)
//   bp   - branch_predictor_if.slave: IF lookup, EX resolution, mispredict/redirect, statistics
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]      tag_t;

    // Table storage, all in flops so reset can clear every entry in one cycle.
    logic        valid_q  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];

    logic [31:0] br_count_q, br_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // ------------------------------------------------------------------
    // IF lookup
    // ------------------------------------------------------------------
    idx_t        if_idx;
    tag_t        if_tag;
    logic        if_hit;
    logic [31:0] if_seq_pc;

    assign if_idx    = bp.if_pc[INDEX_BITS+1:2];
    assign if_tag    = bp.if_pc[31:INDEX_BITS+2];
    assign if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_seq_pc = bp.if_pc + 32'd4;

    // Read straight from the registered table: an EX write to the same
    // index this cycle only becomes visible next cycle.
    always_comb begin
        bp.pred_taken  = 1'b0;
        bp.pred_target = if_seq_pc;
        if (!rst && if_hit && ctr_q[if_idx][1]) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = target_q[if_idx];
        end
    end

    // ------------------------------------------------------------------
    // EX resolution check
    // ------------------------------------------------------------------
    idx_t        ex_idx;
    tag_t        ex_tag;
    logic        ex_hit;
    logic        mis;

    assign ex_idx = bp.ex_pc[INDEX_BITS+1:2];
    assign ex_tag = bp.ex_pc[31:INDEX_BITS+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        mis = 1'b0;
        if (bp.ex_valid && !rst) begin
            if (bp.ex_is_branch) begin
                if (bp.ex_taken != bp.ex_pred_taken)
                    mis = 1'b1;
                else if (bp.ex_taken && (bp.ex_target != bp.ex_pred_target))
                    mis = 1'b1;
            end else if (bp.ex_pred_taken) begin
                // A non-branch that hit a stale entry and was steered away.
                mis = 1'b1;
            end
        end
    end

    assign bp.mispredict  = mis;
    assign bp.redirect_pc = (bp.ex_is_branch && bp.ex_taken) ? bp.ex_target
                                                              : bp.ex_pc + 32'd4;

    // ------------------------------------------------------------------
    // Next-state for the single entry addressed by EX
    // ------------------------------------------------------------------
    logic        ent_we;
    logic        ent_valid_d;
    tag_t        ent_tag_d;
    logic [31:0] ent_target_d;
    logic [1:0]  ent_ctr_d;

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[ex_idx];
        ent_tag_d    = tag_q[ex_idx];
        ent_target_d = target_q[ex_idx];
        ent_ctr_d    = ctr_q[ex_idx];
        if (bp.ex_valid) begin
            if (bp.ex_is_branch) begin
                ent_we = 1'b1;
                if (ex_hit) begin
                    if (bp.ex_taken) begin
                        if (ctr_q[ex_idx] != 2'b11)
                            ent_ctr_d = ctr_q[ex_idx] + 2'b01;
                        ent_target_d = bp.ex_target;
                    end else if (ctr_q[ex_idx] != 2'b00) begin
                        ent_ctr_d = ctr_q[ex_idx] - 2'b01;
                    end
                end else begin
                    // Miss: replace whatever lived here, start weakly biased
                    // toward the outcome just seen.
                    ent_valid_d  = 1'b1;
                    ent_tag_d    = ex_tag;
                    ent_target_d = bp.ex_target;
                    ent_ctr_d    = bp.ex_taken ? 2'b10 : 2'b01;
                end
            end else if (ex_hit) begin
                ent_we      = 1'b1;
                ent_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (bp.ex_valid && bp.ex_is_branch && (br_count_q != 32'hFFFF_FFFF))
            br_count_d = br_count_q + 32'd1;
        if (mis && (miss_count_q != 32'hFFFF_FFFF))
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            if (ent_we) begin
                valid_q[ex_idx]  <= ent_valid_d;
                tag_q[ex_idx]    <= ent_tag_d;
                target_q[ex_idx] <= ent_target_d;
                ctr_q[ex_idx]    <= ent_ctr_d;
            end
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bp.br_count   = br_count_q;
    assign bp.miss_count = miss_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic        rpc_chk;
        logic [31:0] rpc;
        logic        cnt_chk;
        logic [31:0] br;
        logic [31:0] miss;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks   = 0;
    int    failures = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop whatever the driver
    // queued for this cycle and compare away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                cmp({n, ".pred_taken"},  {31'd0, bp_if.pred_taken}, {31'd0, e.pt});
                cmp({n, ".pred_target"}, bp_if.pred_target,          e.ptgt);
                cmp({n, ".mispredict"},  {31'd0, bp_if.mispredict}, {31'd0, e.mis});
                if (e.rpc_chk)
                    cmp({n, ".redirect_pc"}, bp_if.redirect_pc, e.rpc);
                if (e.cnt_chk) begin
                    cmp({n, ".br_count"},   bp_if.br_count,   e.br);
                    cmp({n, ".miss_count"}, bp_if.miss_count, e.miss);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] ipc,
                         input logic v, input logic isbr, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tg,
                         input logic ptk, input logic [31:0] ptg);
        @(posedge clk);
        #1;
        rst                  = r;
        bp_if.if_pc          = ipc;
        bp_if.ex_valid       = v;
        bp_if.ex_is_branch   = isbr;
        bp_if.ex_pc          = pc;
        bp_if.ex_taken       = tk;
        bp_if.ex_target      = tg;
        bp_if.ex_pred_taken  = ptk;
        bp_if.ex_pred_target = ptg;
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(1'b0, ipc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_out(input string nm, input logic pt, input logic [31:0] ptgt,
                              input logic mis, input logic rchk, input logic [31:0] rpc,
                              input logic cchk, input logic [31:0] br, input logic [31:0] miss);
        exp_t e;
        e.pt = pt; e.ptgt = ptgt; e.mis = mis; e.rpc_chk = rchk; e.rpc = rpc;
        e.cnt_chk = cchk; e.br = br; e.miss = miss;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        bp_if.if_pc = 32'h40;
        bp_if.ex_valid = 1'b0; bp_if.ex_is_branch = 1'b0; bp_if.ex_pc = 32'h0;
        bp_if.ex_taken = 1'b0; bp_if.ex_target = 32'h0;
        bp_if.ex_pred_taken = 1'b0; bp_if.ex_pred_target = 32'h0;

        // Reset held with a would-be mispredicting branch in EX.
        drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        expect_out("in_reset", 0, 32'h44, 0, 0, 0, 0, 0, 0);

        idle(32'h40);
        expect_out("post_reset", 0, 32'h44, 0, 0, 0, 1, 0, 0);

        // First taken resolution: miss, allocate with ctr=10.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        expect_out("first_taken", 0, 32'h44, 1, 1, 32'h100, 1, 0, 0);
        idle(32'h40);
        expect_out("pred_after_alloc", 1, 32'h100, 0, 0, 0, 1, 1, 1);

        // Two correct taken resolutions: ctr 10->11->11.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        expect_out("taken_ok1", 1, 32'h100, 0, 1, 32'h100, 1, 1, 1);
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        expect_out("taken_ok2", 1, 32'h100, 0, 1, 32'h100, 1, 2, 1);

        // Not-taken predicted taken: ctr 11->10, still predicts taken.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        expect_out("nt_mis1", 1, 32'h100, 1, 1, 32'h44, 1, 3, 1);
        idle(32'h40);
        expect_out("still_taken", 1, 32'h100, 0, 0, 0, 1, 4, 2);

        // ctr 10->01 (mispredict), then 01->00 (correct not-taken).
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        expect_out("nt_mis2", 1, 32'h100, 1, 1, 32'h44, 1, 4, 2);
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        expect_out("nt_ok", 0, 32'h44, 0, 1, 32'h44, 1, 5, 3);
        idle(32'h40);
        expect_out("now_not_taken", 0, 32'h44, 0, 0, 0, 1, 6, 3);

        // Retrain 00->01->10; same-cycle fetch sees the pre-update counter.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        expect_out("retrain1", 0, 32'h44, 1, 1, 32'h100, 1, 6, 3);
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        expect_out("same_cycle_old", 0, 32'h44, 1, 1, 32'h100, 1, 7, 4);
        idle(32'h40);
        expect_out("same_cycle_new", 1, 32'h100, 0, 0, 0, 1, 8, 5);

        // Same index, different tag.
        idle(32'h140);
        expect_out("alias_tag", 0, 32'h144, 0, 0, 0, 1, 8, 5);

        // Target-only mismatch: ctr 10->11, target becomes 0x200.
        drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        expect_out("target_mis", 1, 32'h100, 1, 1, 32'h200, 1, 8, 5);
        idle(32'h40);
        expect_out("new_target", 1, 32'h200, 0, 0, 0, 1, 9, 6);

        // Aliased non-branch predicted taken: mispredict and invalidate.
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h200);
        expect_out("nonbr_alias", 1, 32'h200, 1, 1, 32'h44, 1, 9, 6);
        idle(32'h40);
        expect_out("invalidated", 0, 32'h44, 0, 0, 0, 1, 9, 7);

        // Non-branch missing the table: nothing happens.
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        expect_out("nonbr_miss", 0, 32'h44, 0, 1, 32'h44, 1, 9, 7);

        // ex_valid=0 with mispredicting fields; also if_pc+4 wrap.
        drive(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
        expect_out("bubble_wrap", 0, 32'h0000_0000, 0, 0, 0, 1, 9, 7);
        idle(32'h40);
        expect_out("bubble_nochg", 0, 32'h44, 0, 0, 0, 1, 9, 7);

        // Train another index, then reset with a mispredicting branch in EX.
        drive(1'b0, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
        expect_out("alloc_80", 0, 32'h84, 1, 1, 32'h300, 1, 9, 7);
        drive(1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 32'h300, 1'b1, 32'h300);
        expect_out("reset_mid", 0, 32'h84, 0, 0, 0, 1, 10, 8);
        idle(32'h80);
        expect_out("reset_cleared_80", 0, 32'h84, 0, 0, 0, 1, 0, 0);
        idle(32'h40);
        expect_out("reset_cleared_40", 0, 32'h44, 0, 0, 0, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
